// File: rtl/phase_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through phases P1..P5 and drives datapath strobes.
// Optional retired-instruction counter enabled by defining PHASE_SEQ_RETIRE_COUNT_EN.
module phase_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic [3:0]  aluFlags,
    input  logic        memReady,
    input  logic        outReady,
    output logic [4:0]  phase,
    output logic        irWrite,
    output logic        pcInc,
    output logic        pcLoad,
    output logic        regRead,
    output logic [3:0]  aluType,
    output logic        aluSrcImm,
    output logic        drWrite,
    output logic        mdrWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        regWrite,
    output logic [1:0]  regWriteSel,
    output logic        outValid,
    output logic        halted,
    output logic [3:0]  flags,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_P1     = 3'd1,
        S_P2     = 3'd2,
        S_P3     = 3'd3,
        S_P4     = 3'd4,
        S_P5     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;

    logic w_is_calc, w_is_load, w_is_store, w_is_grp;
    logic w_is_li, w_is_b, w_is_bcc, w_is_branch;
    logic w_is_halt, w_is_cmp, w_is_out;
    logic w_cond, w_taken;
    logic w_unused_ir;

    // ir[3:0] only matters to the datapath (immediate field), never to control.
    assign w_unused_ir = ^ir[3:0];

    assign w_is_calc   = (ir[15:14] == 2'b11);
    assign w_is_load   = (ir[15:14] == 2'b00);
    assign w_is_store  = (ir[15:14] == 2'b01);
    assign w_is_grp    = (ir[15:14] == 2'b10);
    assign w_is_li     = w_is_grp && (ir[13:11] == 3'b000);
    assign w_is_b      = w_is_grp && (ir[13:11] == 3'b100);
    assign w_is_bcc    = w_is_grp && (ir[13:11] == 3'b111);
    assign w_is_branch = w_is_b || w_is_bcc;
    assign w_is_halt   = w_is_calc && (ir[7:4] == 4'b1111);
    assign w_is_cmp    = w_is_calc && (ir[7:4] == 4'b0101);
    assign w_is_out    = w_is_calc && (ir[7:4] == 4'b1101);

    // Conditions use the latched flags {V,C,Z,S}, i.e. those of the last calc op.
    always_comb begin
        w_cond = 1'b0;
        case (ir[10:8])
            3'b000:  w_cond = r_flags[1];
            3'b001:  w_cond = r_flags[0] ^ r_flags[3];
            3'b010:  w_cond = r_flags[1] | (r_flags[0] ^ r_flags[3]);
            3'b011:  w_cond = ~r_flags[1];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken = w_is_b || (w_is_bcc && w_cond);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        phase       = 5'b00000;
        irWrite     = 1'b0;
        pcInc       = 1'b0;
        pcLoad      = 1'b0;
        regRead     = 1'b0;
        aluType     = 4'b0000;
        aluSrcImm   = 1'b0;
        drWrite     = 1'b0;
        mdrWrite    = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        regWrite    = 1'b0;
        regWriteSel = 2'd0;
        outValid    = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_P1;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (start) w_next = S_P1;
            end
            S_P1: begin
                phase   = 5'b00001;
                memRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcInc   = 1'b1;
                    w_next  = S_P2;
                end
            end
            S_P2: begin
                phase   = 5'b00010;
                regRead = 1'b1;
                if (w_is_halt)                     w_next = S_HALTED;
                else if (w_is_calc)                w_next = S_P3;
                else if (w_is_load || w_is_store)  w_next = S_P3;
                else if (w_is_li)                  w_next = S_P5;
                else if (w_is_branch)              w_next = S_P3;
                else                               w_next = S_P1;
            end
            S_P3: begin
                phase   = 5'b00100;
                drWrite = 1'b1;
                if (w_is_calc) begin
                    aluType = ir[7:4];
                    if (w_is_out)      w_next = S_P4;
                    else if (w_is_cmp) w_next = S_P1;
                    else               w_next = S_P5;
                end else if (w_is_load || w_is_store) begin
                    aluSrcImm = 1'b1;
                    w_next    = S_P4;
                end else begin
                    aluSrcImm = 1'b1;
                    pcLoad    = w_taken;
                    w_next    = S_P1;
                end
            end
            S_P4: begin
                phase = 5'b01000;
                if (w_is_load) begin
                    memRead  = 1'b1;
                    mdrWrite = memReady;
                    if (memReady) w_next = S_P5;
                end else if (w_is_store) begin
                    memWrite = 1'b1;
                    if (memReady) w_next = S_P1;
                end else begin
                    outValid = 1'b1;
                    if (outReady) w_next = S_P1;
                end
            end
            S_P5: begin
                phase    = 5'b10000;
                regWrite = 1'b1;
                if (w_is_load)    regWriteSel = 2'd1;
                else if (w_is_li) regWriteSel = 2'd2;
                else              regWriteSel = 2'd0;
                w_next = S_P1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // OUT never updates flags; HALT leaves from P2 and so never reaches here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= 4'b0000;
        end else if (r_state == S_P3 && w_is_calc && !w_is_out && !w_is_halt) begin
            r_flags <= aluFlags;
        end
    end

    assign flags = r_flags;

`ifdef PHASE_SEQ_RETIRE_COUNT_EN
    logic        w_retire;
    logic [15:0] r_retired;

    // An instruction's final cycle is any execute phase that hands over to P1 or HALTED.
    assign w_retire = (r_state == S_P2 || r_state == S_P3 || r_state == S_P4 || r_state == S_P5)
                   && (w_next == S_P1 || w_next == S_HALTED);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= 16'd0;
        end else if (w_retire) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired = r_retired;
`else
    assign retired = 16'd0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: walks calc, load, CMP/Bcc, B, LI, NOP, OUT, HALT and a mid-store reset.
module tb_phase_sequencer;

    localparam logic [4:0] PH0 = 5'b00000;
    localparam logic [4:0] PH1 = 5'b00001;
    localparam logic [4:0] PH2 = 5'b00010;
    localparam logic [4:0] PH3 = 5'b00100;
    localparam logic [4:0] PH4 = 5'b01000;
    localparam logic [4:0] PH5 = 5'b10000;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [15:0] ir;
    logic [3:0]  aluFlags;
    logic        memReady;
    logic        outReady;
    logic [4:0]  phase;
    logic        irWrite, pcInc, pcLoad, regRead;
    logic [3:0]  aluType;
    logic        aluSrcImm, drWrite, mdrWrite, memRead, memWrite, regWrite;
    logic [1:0]  regWriteSel;
    logic        outValid, halted;
    logic [3:0]  flags;
    logic [15:0] retired;

    int n_checks;
    int n_fail;

    phase_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .ir          (ir),
        .aluFlags    (aluFlags),
        .memReady    (memReady),
        .outReady    (outReady),
        .phase       (phase),
        .irWrite     (irWrite),
        .pcInc       (pcInc),
        .pcLoad      (pcLoad),
        .regRead     (regRead),
        .aluType     (aluType),
        .aluSrcImm   (aluSrcImm),
        .drWrite     (drWrite),
        .mdrWrite    (mdrWrite),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .regWrite    (regWrite),
        .regWriteSel (regWriteSel),
        .outValid    (outValid),
        .halted      (halted),
        .flags       (flags),
        .retired     (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ret_exp(input int n);
`ifdef PHASE_SEQ_RETIRE_COUNT_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        ir       = 16'h0000;
        aluFlags = 4'b0000;
        memReady = 1'b0;
        outReady = 1'b0;
        #12;
        chk("rst_phase",   {11'd0, phase},  16'd0);
        chk("rst_halted",  {15'd0, halted}, 16'd0);
        chk("rst_flags",   {12'd0, flags},  16'd0);
        chk("rst_retired", retired,         16'd0);
        chk("rst_memRead", {15'd0, memRead}, 16'd0);
        reset_n = 1'b1;
        tick(); #1;
        chk("idle_hold", {11'd0, phase}, {11'd0, PH0});

        // Calc: ALU op 0000, zero-wait memory
        ir = 16'hC800; aluFlags = 4'b0010; memReady = 1'b1; start = 1'b1;
        tick(); start = 1'b0; #1;
        chk("calc_p1_phase", {11'd0, phase}, {11'd0, PH1});
        chk("calc_p1_memRead", {15'd0, memRead}, 16'd1);
        chk("calc_p1_irWrite", {15'd0, irWrite}, 16'd1);
        chk("calc_p1_pcInc", {15'd0, pcInc}, 16'd1);
        tick(); #1;
        chk("calc_p2_phase", {11'd0, phase}, {11'd0, PH2});
        chk("calc_p2_regRead", {15'd0, regRead}, 16'd1);
        tick(); #1;
        chk("calc_p3_phase", {11'd0, phase}, {11'd0, PH3});
        chk("calc_p3_drWrite", {15'd0, drWrite}, 16'd1);
        chk("calc_p3_aluType", {12'd0, aluType}, 16'd0);
        tick(); #1;
        chk("calc_p5_phase", {11'd0, phase}, {11'd0, PH5});
        chk("calc_p5_regWrite", {15'd0, regWrite}, 16'd1);
        chk("calc_p5_sel", {14'd0, regWriteSel}, 16'd0);
        chk("calc_flags", {12'd0, flags}, 16'h0002);
        tick(); #1;
        chk("calc_next_p1", {11'd0, phase}, {11'd0, PH1});
        chk("calc_retired", retired, ret_exp(1));

        // Load with two wait cycles in P4
        ir = 16'h0105;
        tick(); #1;
        chk("ld_p2_phase", {11'd0, phase}, {11'd0, PH2});
        tick(); #1;
        chk("ld_p3_phase", {11'd0, phase}, {11'd0, PH3});
        chk("ld_p3_imm", {15'd0, aluSrcImm}, 16'd1);
        memReady = 1'b0;
        tick(); #1;
        chk("ld_p4a_phase", {11'd0, phase}, {11'd0, PH4});
        chk("ld_p4a_memRead", {15'd0, memRead}, 16'd1);
        chk("ld_p4a_mdrWrite", {15'd0, mdrWrite}, 16'd0);
        tick(); #1;
        chk("ld_p4b_phase", {11'd0, phase}, {11'd0, PH4});
        chk("ld_p4b_memRead", {15'd0, memRead}, 16'd1);
        chk("ld_p4b_mdrWrite", {15'd0, mdrWrite}, 16'd0);
        memReady = 1'b1; #1;
        chk("ld_p4c_phase", {11'd0, phase}, {11'd0, PH4});
        chk("ld_p4c_mdrWrite", {15'd0, mdrWrite}, 16'd1);
        tick(); #1;
        chk("ld_p5_phase", {11'd0, phase}, {11'd0, PH5});
        chk("ld_p5_sel", {14'd0, regWriteSel}, 16'd1);
        chk("ld_p5_mdrWrite", {15'd0, mdrWrite}, 16'd0);
        tick();

        // CMP with Z=1, then BE taken (live flags deliberately differ)
        ir = 16'hC050; aluFlags = 4'b0010;
        tick(); tick(); #1;
        chk("cmp1_aluType", {12'd0, aluType}, 16'd5);
        tick(); #1;
        chk("cmp1_to_p1", {11'd0, phase}, {11'd0, PH1});
        chk("cmp1_flags", {12'd0, flags}, 16'h0002);
        ir = 16'hB800; aluFlags = 4'b0000;
        tick(); tick(); #1;
        chk("be_taken_phase", {11'd0, phase}, {11'd0, PH3});
        chk("be_taken_pcLoad", {15'd0, pcLoad}, 16'd1);
        tick(); #1;
        chk("be_taken_to_p1", {11'd0, phase}, {11'd0, PH1});

        // CMP with Z=0, then BE not taken; branch P3 must not latch flags
        ir = 16'hC050; aluFlags = 4'b0000;
        tick(); tick(); tick(); #1;
        chk("cmp2_flags", {12'd0, flags}, 16'h0000);
        ir = 16'hB800; aluFlags = 4'b1111;
        tick(); tick(); #1;
        chk("be_nt_pcLoad", {15'd0, pcLoad}, 16'd0);
        tick(); #1;
        chk("be_nt_flags", {12'd0, flags}, 16'h0000);

        // Unconditional B
        ir = 16'hA000;
        tick(); tick(); #1;
        chk("b_pcLoad", {15'd0, pcLoad}, 16'd1);
        tick();

        // LI goes P2 -> P5
        ir = 16'h8000;
        tick(); tick(); #1;
        chk("li_phase", {11'd0, phase}, {11'd0, PH5});
        chk("li_sel", {14'd0, regWriteSel}, 16'd2);
        tick();

        // NOP returns from P2 to P1
        ir = 16'h8800;
        tick(); #1;
        chk("nop_p2", {11'd0, phase}, {11'd0, PH2});
        tick(); #1;
        chk("nop_to_p1", {11'd0, phase}, {11'd0, PH1});

        // OUT with three not-ready cycles
        ir = 16'hC0D0;
        tick(); tick(); #1;
        chk("out_aluType", {12'd0, aluType}, 16'h000D);
        outReady = 1'b0;
        tick(); #1;
        chk("out_w1_phase", {11'd0, phase}, {11'd0, PH4});
        chk("out_w1_valid", {15'd0, outValid}, 16'd1);
        tick(); #1;
        chk("out_w2_valid", {15'd0, outValid}, 16'd1);
        tick(); #1;
        chk("out_w3_valid", {15'd0, outValid}, 16'd1);
        outReady = 1'b1; #1;
        chk("out_w4_valid", {15'd0, outValid}, 16'd1);
        tick(); #1;
        chk("out_to_p1", {11'd0, phase}, {11'd0, PH1});
        chk("out_flags_kept", {12'd0, flags}, 16'h0000);

        // HALT, then restart with start
        ir = 16'hC0F0;
        tick(); #1;
        chk("halt_p2", {11'd0, phase}, {11'd0, PH2});
        tick(); #1;
        chk("halt_halted", {15'd0, halted}, 16'd1);
        chk("halt_phase", {11'd0, phase}, {11'd0, PH0});
        tick(); #1;
        chk("halt_stays", {15'd0, halted}, 16'd1);
        chk("halt_retired", retired, ret_exp(11));
        start = 1'b1;
        tick(); start = 1'b0; #1;
        chk("restart_phase", {11'd0, phase}, {11'd0, PH1});
        chk("restart_halted", {15'd0, halted}, 16'd0);

        // Store interrupted by async reset in P4
        ir = 16'h4000;
        tick(); tick();
        memReady = 1'b0;
        tick(); #1;
        chk("st_p4_phase", {11'd0, phase}, {11'd0, PH4});
        chk("st_p4_memWrite", {15'd0, memWrite}, 16'd1);
        reset_n = 1'b0; #1;
        chk("st_rst_memWrite", {15'd0, memWrite}, 16'd0);
        chk("st_rst_phase", {11'd0, phase}, {11'd0, PH0});
        chk("st_rst_retired", retired, 16'd0);
        reset_n = 1'b1; memReady = 1'b1;
        tick(); #1;
        chk("st_rst_idle", {11'd0, phase}, {11'd0, PH0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
